// File: rtl/elevator_if.sv
// Request and status bundle between the call panel side and the elevator floor sequencer.
// master drives call requests; slave is the controller that reports pending, strobes and status.
interface elevator_if #(
  parameter int unsigned N_FLOORS = 4,
  parameter int unsigned FLOOR_W  = 2
);
  logic [N_FLOORS-1:0] call_req;
  logic [N_FLOORS-1:0] pending;
  logic [N_FLOORS-1:0] j_set;
  logic [N_FLOORS-1:0] k_clr;
  logic [FLOOR_W-1:0]  current_floor;
  logic                moving_up;
  logic                moving_down;
  logic                door_open;

  modport master (
    output call_req,
    input  pending,
    input  j_set,
    input  k_clr,
    input  current_floor,
    input  moving_up,
    input  moving_down,
    input  door_open
  );

  modport slave (
    input  call_req,
    output pending,
    output j_set,
    output k_clr,
    output current_floor,
    output moving_up,
    output moving_down,
    output door_open
  );
endinterface

// File: rtl/elevator_ctrl.sv
// SCAN elevator sequencer: latches floor calls, moves one floor per MOVE_CYCLES, holds the door
// for DOOR_CYCLES, and emits J/K strobes for the downstream per-floor JK request registers.
module elevator_ctrl #(
  parameter int unsigned N_FLOORS    = 4,
  parameter int unsigned FLOOR_W     = 2,
  parameter int unsigned MOVE_CYCLES = 8,
  parameter int unsigned DOOR_CYCLES = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  elevator_if.slave  bus
);

  localparam int unsigned MoveW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam int unsigned DoorW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [MoveW-1:0]    MoveLast = MoveW'(MOVE_CYCLES - 1);
  localparam logic [DoorW-1:0]    DoorLast = DoorW'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0]  TopFloor = FLOOR_W'(N_FLOORS - 1);
  localparam logic [N_FLOORS-1:0] OneHot0  = N_FLOORS'(1);

  typedef enum logic [1:0] {StIdle, StMoveUp, StMoveDown, StDoor} state_e;

  state_e              state_q, state_d;
  logic                dir_up_q, dir_up_d;
  logic [FLOOR_W-1:0]  floor_q, floor_d;
  logic [N_FLOORS-1:0] pending_q, pending_d;
  logic [N_FLOORS-1:0] j_set_q, j_set_d;
  logic [N_FLOORS-1:0] k_clr_q, k_clr_d;
  logic [MoveW-1:0]    move_q, move_d;
  logic [DoorW-1:0]    door_q, door_d;

  logic [N_FLOORS-1:0] floor_oh, arr_oh, excl;
  logic [FLOOR_W-1:0]  arr_floor;
  logic                above, below, at_floor_call;

  always_comb begin
    floor_oh = OneHot0 << floor_q;
    above    = 1'b0;
    below    = 1'b0;
    for (int unsigned i = 0; i < N_FLOORS; i++) begin
      if (pending_q[i] && (FLOOR_W'(i) > floor_q)) above = 1'b1;
      if (pending_q[i] && (FLOOR_W'(i) < floor_q)) below = 1'b1;
    end
    at_floor_call = |(bus.call_req & floor_oh);
  end

  always_comb begin
    state_d   = state_q;
    dir_up_d  = dir_up_q;
    floor_d   = floor_q;
    move_d    = move_q;
    door_d    = door_q;
    k_clr_d   = '0;
    excl      = '0;
    arr_floor = floor_q;
    arr_oh    = floor_oh;

    unique case (state_q)
      StIdle: begin
        excl   = floor_oh;
        move_d = '0;
        door_d = '0;
        if (at_floor_call) begin
          state_d = StDoor;
        end else if (above && (dir_up_q || !below)) begin
          state_d  = StMoveUp;
          dir_up_d = 1'b1;
        end else if (below) begin
          state_d  = StMoveDown;
          dir_up_d = 1'b0;
        end
      end

      StMoveUp, StMoveDown: begin
        if ((state_q == StMoveUp && floor_q == TopFloor) ||
            (state_q == StMoveDown && floor_q == '0)) begin
          // Unreachable by construction; never run off either end of the shaft.
          state_d = StIdle;
          move_d  = '0;
        end else if (move_q == MoveLast) begin
          move_d = '0;
          if (state_q == StMoveUp) begin
            arr_floor = floor_q + FLOOR_W'(1);
            arr_oh    = floor_oh << 1;
          end else begin
            arr_floor = floor_q - FLOOR_W'(1);
            arr_oh    = floor_oh >> 1;
          end
          floor_d = arr_floor;
          // A call landing on the arrival edge is served, not latched.
          excl    = arr_oh;
          if (|((pending_q | bus.call_req) & arr_oh)) begin
            state_d = StDoor;
            door_d  = '0;
            k_clr_d = arr_oh;
          end
        end else begin
          move_d = move_q + MoveW'(1);
        end
      end

      StDoor: begin
        excl = floor_oh;
        if (at_floor_call) begin
          door_d = '0;
        end else if (door_q == DoorLast) begin
          door_d = '0;
          if (dir_up_q && above) begin
            state_d = StMoveUp;
          end else if (!dir_up_q && below) begin
            state_d = StMoveDown;
          end else if (above) begin
            state_d  = StMoveUp;
            dir_up_d = 1'b1;
          end else if (below) begin
            state_d  = StMoveDown;
            dir_up_d = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          door_d = door_q + DoorW'(1);
        end
      end

      default: state_d = StIdle;
    endcase

    j_set_d   = bus.call_req & ~pending_q & ~excl;
    pending_d = (pending_q | j_set_d) & ~k_clr_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      dir_up_q  <= 1'b1;
      floor_q   <= '0;
      pending_q <= '0;
      j_set_q   <= '0;
      k_clr_q   <= '0;
      move_q    <= '0;
      door_q    <= '0;
    end else begin
      state_q   <= state_d;
      dir_up_q  <= dir_up_d;
      floor_q   <= floor_d;
      pending_q <= pending_d;
      j_set_q   <= j_set_d;
      k_clr_q   <= k_clr_d;
      move_q    <= move_d;
      door_q    <= door_d;
    end
  end

  assign bus.pending       = pending_q;
  assign bus.j_set         = j_set_q;
  assign bus.k_clr         = k_clr_q;
  assign bus.current_floor = floor_q;
  assign bus.moving_up     = (state_q == StMoveUp);
  assign bus.moving_down   = (state_q == StMoveDown);
  assign bus.door_open     = (state_q == StDoor);

endmodule

// File: tb/tb_elevator_ctrl.sv
// Scoreboard bench for elevator_ctrl: stimulus pushes expected J/K/door/motion events with their
// cycle numbers; a negedge monitor pops and compares each event the DUT produces.
module tb_elevator_ctrl;

  localparam int EvJ    = 0;
  localparam int EvK    = 1;
  localparam int EvDoor = 2;
  localparam int EvUp   = 3;
  localparam int EvDn   = 4;

  typedef struct {
    int kind;
    int value;
    int floor;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  ev_t  exp_q[$];

  logic up_prev, dn_prev, door_prev;
  int   door_start;

  elevator_if #(.N_FLOORS(4), .FLOOR_W(2)) bus ();

  elevator_ctrl #(
    .N_FLOORS   (4),
    .FLOOR_W    (2),
    .MOVE_CYCLES(8),
    .DOOR_CYCLES(6)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int k, input int v, input int f, input int c);
    ev_t e;
    e.kind  = k;
    e.value = v;
    e.floor = f;
    e.cyc   = c;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_ev(input int k, input int v, input int f);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got kind=%0d val=%0d floor=%0d cyc=%0d, expected none",
               k, v, f, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.value != v || e.floor != f || e.cyc != cyc) begin
        failures++;
        $display("FAIL event: got kind=%0d val=%0d floor=%0d cyc=%0d, expected kind=%0d val=%0d floor=%0d cyc=%0d",
                 k, v, f, cyc, e.kind, e.value, e.floor, e.cyc);
      end
    end
  endtask

  // Monitor: same-cycle events are reported in the fixed order J, K, door close, up, down.
  always @(negedge clk) begin
    if (!rst_n) begin
      up_prev   <= 1'b0;
      dn_prev   <= 1'b0;
      door_prev <= 1'b0;
    end else begin
      if (bus.j_set != '0) check_ev(EvJ, int'(bus.j_set), 0);
      if (bus.k_clr != '0) check_ev(EvK, int'(bus.k_clr), int'(bus.current_floor));
      if (door_prev && !bus.door_open)
        check_ev(EvDoor, cyc - door_start, int'(bus.current_floor));
      if (bus.door_open && !door_prev) door_start <= cyc;
      if (bus.moving_up && !up_prev) check_ev(EvUp, 0, int'(bus.current_floor));
      if (bus.moving_down && !dn_prev) check_ev(EvDn, 0, int'(bus.current_floor));
      up_prev   <= bus.moving_up;
      dn_prev   <= bus.moving_down;
      door_prev <= bus.door_open;
    end
  end

  task automatic at_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Called at a negedge; the request is sampled on the next n rising edges.
  task automatic pulse(input logic [3:0] req, input int n);
    bus.call_req = req;
    repeat (n) @(negedge clk);
    bus.call_req = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int t;
    rst_n        = 1'b0;
    bus.call_req = '0;
    repeat (3) @(negedge clk);
    chk("rst_pending", int'(bus.pending), 0);
    chk("rst_j_set", int'(bus.j_set), 0);
    chk("rst_k_clr", int'(bus.k_clr), 0);
    chk("rst_floor", int'(bus.current_floor), 0);
    chk("rst_up", int'(bus.moving_up), 0);
    chk("rst_down", int'(bus.moving_down), 0);
    chk("rst_door", int'(bus.door_open), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single call from floor 0 to floor 3.
    t = cyc + 1;
    push(EvJ, 8, 0, t);
    push(EvUp, 0, 0, t + 1);
    push(EvK, 8, 3, t + 25);
    push(EvDoor, 6, 3, t + 31);
    pulse(4'b1000, 1);
    at_cyc(t + 35);
    chk("single_pending", int'(bus.pending), 0);
    chk("single_floor", int'(bus.current_floor), 3);

    // Reset in the middle of a downward move.
    t = cyc + 1;
    push(EvJ, 1, 0, t);
    push(EvDn, 0, 3, t + 1);
    pulse(4'b0001, 1);
    at_cyc(t + 12);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_pending", int'(bus.pending), 0);
    chk("midrst_floor", int'(bus.current_floor), 0);
    chk("midrst_down", int'(bus.moving_down), 0);
    chk("midrst_k_clr", int'(bus.k_clr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Call at the current floor while idle: door only, no latch.
    t = cyc + 1;
    push(EvDoor, 6, 0, t + 6);
    pulse(4'b0001, 1);
    chk("atfloor_pending", int'(bus.pending), 0);
    at_cyc(t + 8);

    // SCAN ordering with a held request and a mid-move call.
    t = cyc + 1;
    push(EvJ, 2, 0, t);
    push(EvUp, 0, 0, t + 1);
    push(EvK, 2, 1, t + 9);
    push(EvJ, 9, 0, t + 10);
    push(EvDoor, 6, 1, t + 15);
    push(EvUp, 0, 1, t + 15);
    push(EvJ, 4, 0, t + 18);
    push(EvK, 4, 2, t + 23);
    push(EvDoor, 6, 2, t + 29);
    push(EvUp, 0, 2, t + 29);
    push(EvK, 8, 3, t + 37);
    push(EvDoor, 6, 3, t + 43);
    push(EvDn, 0, 3, t + 43);
    push(EvK, 1, 0, t + 67);
    push(EvDoor, 6, 0, t + 73);
    pulse(4'b0010, 1);
    at_cyc(t + 9);
    pulse(4'b1001, 3);
    at_cyc(t + 17);
    pulse(4'b0100, 1);
    at_cyc(t + 76);

    // Door extension: same-floor call during the 4th door cycle at floor 2.
    t = cyc + 1;
    push(EvJ, 4, 0, t);
    push(EvUp, 0, 0, t + 1);
    push(EvK, 4, 2, t + 17);
    push(EvDoor, 10, 2, t + 27);
    pulse(4'b0100, 1);
    at_cyc(t + 20);
    pulse(4'b0100, 1);
    at_cyc(t + 30);

    // Call lands on the arrival edge at floor 1: served, not latched.
    t = cyc + 1;
    push(EvJ, 1, 0, t);
    push(EvDn, 0, 2, t + 1);
    push(EvK, 2, 1, t + 9);
    push(EvDoor, 6, 1, t + 15);
    push(EvDn, 0, 1, t + 15);
    push(EvK, 1, 0, t + 23);
    push(EvDoor, 6, 0, t + 29);
    pulse(4'b0001, 1);
    at_cyc(t + 8);
    pulse(4'b0010, 1);
    chk("simul_pending", int'(bus.pending), 1);
    at_cyc(t + 32);
    chk("final_pending", int'(bus.pending), 0);
    chk("final_floor", int'(bus.current_floor), 0);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events: got %0d outstanding expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
